// File: rtl/pll_sweep_scheduler_pkg.sv
// Shared definitions for the PLL frequency-sweep scheduler. The state encoding
// and the start-frequency constant are also used by the PLL controller and by
// debug display logic.
package pll_sweep_scheduler_pkg;

    // Width of frequency values exchanged with the PLL controller
    localparam int FREQ_W = 9;

    // Frequency the PLL controller reports after its first press following reset
    localparam int PLL_START_FREQ = 100;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PRESS     = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_LOCK = 3'd3,
        ST_SETTLE    = 3'd4,
        ST_MEASURE   = 3'd5,
        ST_CHECK     = 3'd6,
        ST_DONE      = 3'd7
    } sweep_state_t;

    // Largest of three interval lengths; sizes the shared interval timer
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_sweep_scheduler_timer.sv
// Loadable down-counter with a zero flag. One instance is shared between the
// press, settle and lock-timeout intervals, which never overlap.
module sweep_timer #(
    parameter int unsigned W = 21
) (
    input  logic         CLK_50,
    input  logic         reset_n,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count;

    // Load takes priority; otherwise count down and rest at zero
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pll_sweep_scheduler.sv
// Automatic sequencer for the PLL frequency sweep: presses next_frequency,
// waits for lock, settles, triggers one measurement per point, and stops at
// the programmed end frequency, on abort, or on lock timeout.
module pll_sweep_scheduler #(
    parameter int unsigned PRESS_CYCLES  = 8,
    parameter int unsigned SETTLE_CYCLES = 1024,
    parameter int unsigned LOCK_TIMEOUT  = 1 << 20,
    parameter int unsigned FREQ_W        = pll_sweep_scheduler_pkg::FREQ_W
) (
    input  logic              CLK_50,
    input  logic              reset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [3:0]        step,
    input  logic [FREQ_W-1:0] stop_freq,
    input  logic [FREQ_W-1:0] frequency,
    input  logic              freq_ready,
    input  logic              meas_done,
    output logic              next_frequency,
    output logic [3:0]        add,
    output logic              meas_start,
    output logic              sweep_busy,
    output logic              sweep_done,
    output logic              lock_err,
    output logic [FREQ_W-1:0] point_count
);

    import pll_sweep_scheduler_pkg::*;

    localparam int unsigned TIMER_W =
        $clog2(max3(PRESS_CYCLES, SETTLE_CYCLES, LOCK_TIMEOUT) + 1);

    sweep_state_t      state;
    sweep_state_t      next_state;

    logic              timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic              timer_zero;

    logic              abort_pending;
    logic              abort_any;
    logic              lock_err_set;
    logic              count_inc;
    logic [FREQ_W:0]   next_sum;

    sweep_timer #(
        .W (TIMER_W)
    ) u_timer (
        .CLK_50     (CLK_50),
        .reset_n    (reset_n),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    // A same-cycle abort acts like one already pending
    assign abort_any = abort_pending | abort;

    // Next requested frequency, one bit wider so an overflow ends the sweep
    assign next_sum = {1'b0, frequency} + (FREQ_W + 1)'(add);

    // State register
    // NOTE: asynchronous active-low reset; every register in this block is
    // reset so outputs are defined the moment reset_n falls.
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and interval-timer control
    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        next_state   = state;
        timer_load   = 1'b0;
        timer_value  = '0;
        lock_err_set = 1'b0;
        count_inc    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    if (step == 4'd0) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state  = ST_PRESS;
                        timer_load  = 1'b1;
                        timer_value = TIMER_W'(PRESS_CYCLES - 1);
                    end
                end
            end

            ST_PRESS: begin
                if (timer_zero) begin
                    next_state = ST_RELEASE;
                end
            end

            ST_RELEASE: begin
                next_state  = ST_WAIT_LOCK;
                timer_load  = 1'b1;
                timer_value = TIMER_W'(LOCK_TIMEOUT - 1);
            end

            ST_WAIT_LOCK: begin
                if (freq_ready && !next_frequency) begin
                    next_state  = ST_SETTLE;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(SETTLE_CYCLES - 1);
                end else if (abort_any) begin
                    next_state = ST_DONE;
                end else if (timer_zero) begin
                    next_state   = ST_DONE;
                    lock_err_set = 1'b1;
                end
            end

            ST_SETTLE: begin
                if (timer_zero) begin
                    next_state = ST_MEASURE;
                end
            end

            ST_MEASURE: begin
                if (meas_done) begin
                    next_state = ST_CHECK;
                    count_inc  = 1'b1;
                end
            end

            ST_CHECK: begin
                if (abort_any) begin
                    next_state = ST_DONE;
                end else if (next_sum > {1'b0, stop_freq}) begin
                    next_state = ST_DONE;
                end else begin
                    next_state  = ST_PRESS;
                    timer_load  = 1'b1;
                    timer_value = TIMER_W'(PRESS_CYCLES - 1);
                end
            end

            ST_DONE: begin
                next_state = ST_IDLE;
            end

            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Registered outputs, decoded from the state being entered
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            next_frequency <= 1'b0;
            meas_start     <= 1'b0;
            sweep_busy     <= 1'b0;
            sweep_done     <= 1'b0;
        end else begin
            next_frequency <= (next_state == ST_PRESS);
            meas_start     <= (state == ST_SETTLE) && (next_state == ST_MEASURE);
            sweep_busy     <= (next_state != ST_IDLE);
            sweep_done     <= (next_state == ST_DONE);
        end
    end

    // Per-sweep context: latched step, point counter and sticky lock error
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            add         <= 4'd0;
            point_count <= '0;
            lock_err    <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            add         <= step;
            point_count <= '0;
            lock_err    <= 1'b0;
        end else begin
            if (count_inc && (point_count != '1)) begin
                point_count <= point_count + {{(FREQ_W - 1){1'b0}}, 1'b1};
            end
            if (lock_err_set) begin
                lock_err <= 1'b1;
            end
        end
    end

    // Abort is remembered until a safe point (WAIT_LOCK or CHECK) consumes it
    always_ff @(posedge CLK_50 or negedge reset_n) begin
        if (!reset_n) begin
            abort_pending <= 1'b0;
        end else if (state == ST_IDLE || state == ST_DONE) begin
            abort_pending <= 1'b0;
        end else if (abort) begin
            abort_pending <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pll_sweep_scheduler.sv
// Self-checking bench for pll_sweep_scheduler: a PLL-controller model and a
// measurement-unit model respond to the DUT; expected measurement frequencies
// are queued by the stimulus and popped on each meas_start.
module tb_pll_sweep_scheduler;

    localparam int unsigned TB_PRESS  = 4;
    localparam int unsigned TB_SETTLE = 16;
    localparam int unsigned TB_LOCK   = 200;
    localparam int          LOCK_DELAY = 50;
    localparam int          MEAS_DELAY = 10;

    logic       CLK_50;
    logic       reset_n;
    logic       start;
    logic       abort;
    logic [3:0] step;
    logic [8:0] stop_freq;
    logic [8:0] frequency;
    logic       freq_ready;
    logic       meas_done;
    logic       next_frequency;
    logic [3:0] add;
    logic       meas_start;
    logic       sweep_busy;
    logic       sweep_done;
    logic       lock_err;
    logic [8:0] point_count;

    pll_sweep_scheduler #(
        .PRESS_CYCLES  (TB_PRESS),
        .SETTLE_CYCLES (TB_SETTLE),
        .LOCK_TIMEOUT  (TB_LOCK),
        .FREQ_W        (9)
    ) dut (
        .CLK_50         (CLK_50),
        .reset_n        (reset_n),
        .start          (start),
        .abort          (abort),
        .step           (step),
        .stop_freq      (stop_freq),
        .frequency      (frequency),
        .freq_ready     (freq_ready),
        .meas_done      (meas_done),
        .next_frequency (next_frequency),
        .add            (add),
        .meas_start     (meas_start),
        .sweep_busy     (sweep_busy),
        .sweep_done     (sweep_done),
        .lock_err       (lock_err),
        .point_count    (point_count)
    );

    initial CLK_50 = 1'b0;
    always #5 CLK_50 = ~CLK_50;

    int n_asserts = 0;
    int n_fail    = 0;
    int cyc       = 0;

    logic [8:0] exp_q[$];

    // Monitor counters
    int press_cnt   = 0;
    int ms_cnt      = 0;
    int done_cnt    = 0;
    int release_cyc = 0;
    int done_cyc    = 0;
    int press_width = 0;
    logic mon_prev_nf = 1'b0;
    logic mon_prev_ms = 1'b0;

    // PLL / measurement model state
    logic       pll_started = 1'b0;
    logic [8:0] pending     = 9'd0;
    int         pll_press   = 0;
    int         lock_fail_from = 1000;
    int         lock_cnt    = 0;
    int         meas_cnt    = 0;
    logic       mdl_prev_nf = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK_50);
        #1;
    endtask

    always @(posedge CLK_50) cyc++;

    // Monitor: press widths, measurement scoreboard, done pulses
    always @(negedge CLK_50) begin
        if (!reset_n) begin
            mon_prev_nf = 1'b0;
            mon_prev_ms = 1'b0;
            press_width = 0;
        end else begin
            if (next_frequency) begin
                press_width++;
                if (!mon_prev_nf) press_cnt++;
            end else if (mon_prev_nf) begin
                check("press_width", press_width, TB_PRESS);
                press_width = 0;
                release_cyc = cyc;
            end
            if (meas_start) begin
                ms_cnt++;
                check("meas_start_pulse", 32'(mon_prev_ms), 32'd0);
                check("meas_q_nonempty", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) check("meas_freq", 32'(frequency), 32'(exp_q.pop_front()));
            end
            if (sweep_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            mon_prev_nf = next_frequency;
            mon_prev_ms = meas_start;
        end
    end

    // PLL-controller and measurement-unit models
    always @(negedge CLK_50) begin
        if (!reset_n) begin
            pll_started = 1'b0;
            pending     = 9'd0;
            pll_press   = 0;
            frequency   = 9'd0;
            freq_ready  = 1'b0;
            lock_cnt    = 0;
            meas_cnt    = 0;
            meas_done   = 1'b0;
            mdl_prev_nf = 1'b0;
        end else begin
            meas_done = 1'b0;
            if (next_frequency && !mdl_prev_nf) begin
                freq_ready = 1'b0;
                pll_press++;
                pending = pll_started ? pending + 9'(add) : 9'd100;
                pll_started = 1'b1;
                lock_cnt = 0;
            end
            if (!next_frequency && mdl_prev_nf) begin
                if (pll_press < lock_fail_from) lock_cnt = LOCK_DELAY;
            end else if (lock_cnt > 0) begin
                lock_cnt--;
                if (lock_cnt == 0) begin
                    frequency  = pending;
                    freq_ready = 1'b1;
                end
            end
            if (meas_start) begin
                meas_cnt = MEAS_DELAY;
            end else if (meas_cnt > 0) begin
                meas_cnt--;
                if (meas_cnt == 0) meas_done = 1'b1;
            end
            mdl_prev_nf = next_frequency;
        end
    end

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic clear_counts();
        press_cnt = 0;
        ms_cnt    = 0;
        done_cnt  = 0;
        exp_q.delete();
    endtask

    task automatic pulse_start(input logic with_abort);
        start = 1'b1;
        abort = with_abort;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int i;
        i = 0;
        while (done_cnt == 0 && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(done_cnt != 0), 32'd1);
    endtask

    task automatic wait_meas(input int n, input int budget, input string tag);
        int i;
        i = 0;
        while (ms_cnt < n && i < budget) begin
            tick();
            i++;
        end
        check(tag, 32'(ms_cnt >= n), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        abort     = 1'b0;
        step      = 4'd0;
        stop_freq = 9'd0;

        // Reset state
        repeat (2) tick();
        check("rst_next_frequency", 32'(next_frequency), 32'd0);
        check("rst_sweep_busy",     32'(sweep_busy),     32'd0);
        check("rst_meas_start",     32'(meas_start),     32'd0);
        check("rst_sweep_done",     32'(sweep_done),     32'd0);
        check("rst_lock_err",       32'(lock_err),       32'd0);
        check("rst_point_count",    32'(point_count),    32'd0);
        check("rst_add",            32'(add),            32'd0);
        reset_n = 1'b1;
        tick();

        // Normal sweep: 100,104,108,112
        clear_counts();
        step = 4'd4;
        stop_freq = 9'd112;
        for (int k = 0; k < 4; k++) exp_q.push_back(9'(100 + 4 * k));
        pulse_start(1'b0);
        check("norm_busy", 32'(sweep_busy), 32'd1);
        check("norm_add",  32'(add),        32'd4);
        wait_done(2000, "norm_done_seen");
        check("norm_points",   32'(point_count), 32'd4);
        check("norm_meas_cnt", 32'(ms_cnt),      32'd4);
        check("norm_presses",  32'(press_cnt),   32'd4);
        check("norm_q_empty",  32'(exp_q.size()), 32'd0);
        check("norm_lock_err", 32'(lock_err),    32'd0);
        tick();
        check("norm_busy_after", 32'(sweep_busy), 32'd0);
        repeat (5) tick();
        check("norm_one_done", 32'(done_cnt), 32'd1);

        // Abort while the second point is being measured
        do_reset();
        clear_counts();
        step = 4'd4;
        stop_freq = 9'd200;
        exp_q.push_back(9'd100);
        exp_q.push_back(9'd104);
        pulse_start(1'b0);
        wait_meas(2, 1000, "abort_second_meas");
        repeat (3) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        wait_done(200, "abort_done_seen");
        check("abort_points",  32'(point_count), 32'd2);
        check("abort_presses", 32'(press_cnt),   32'd2);
        check("abort_lock_err", 32'(lock_err),   32'd0);
        check("abort_q_empty", 32'(exp_q.size()), 32'd0);

        // Wrap boundary: 100..505 in steps of 15, 505+15 > 511 ends the sweep
        do_reset();
        clear_counts();
        step = 4'd15;
        stop_freq = 9'd511;
        for (int k = 0; k < 28; k++) exp_q.push_back(9'(100 + 15 * k));
        pulse_start(1'b0);
        wait_done(5000, "wrap_done_seen");
        check("wrap_points",    32'(point_count), 32'd28);
        check("wrap_presses",   32'(press_cnt),   32'd28);
        check("wrap_last_freq", 32'(frequency),   32'd505);
        check("wrap_q_empty",   32'(exp_q.size()), 32'd0);

        // Lock timeout on the second press
        do_reset();
        clear_counts();
        lock_fail_from = 2;
        step = 4'd4;
        stop_freq = 9'd200;
        exp_q.push_back(9'd100);
        pulse_start(1'b0);
        wait_done(1000, "lock_done_seen");
        check("lock_err_set",   32'(lock_err),    32'd1);
        check("lock_points",    32'(point_count), 32'd1);
        check("lock_presses",   32'(press_cnt),   32'd2);
        check("lock_interval_ok",
              32'((done_cyc - release_cyc) >= int'(TB_LOCK) &&
                  (done_cyc - release_cyc) <= int'(TB_LOCK) + 2), 32'd1);
        repeat (5) tick();
        check("lock_err_sticky", 32'(lock_err), 32'd1);

        // Zero step: immediate end with no points and no press
        clear_counts();
        lock_fail_from = 1000;
        step = 4'd0;
        pulse_start(1'b0);
        wait_done(3, "zero_done_seen");
        check("zero_points",   32'(point_count), 32'd0);
        check("zero_presses",  32'(press_cnt),   32'd0);
        check("zero_lock_err", 32'(lock_err),    32'd0);
        repeat (3) tick();
        check("zero_idle", 32'(sweep_busy), 32'd0);

        // Restart with step=1 (controller continues from its last request, 104);
        // abort in the same cycle as start must be ignored
        clear_counts();
        step = 4'd1;
        stop_freq = 9'd106;
        exp_q.push_back(9'd105);
        exp_q.push_back(9'd106);
        pulse_start(1'b1);
        check("restart_busy",     32'(sweep_busy), 32'd1);
        check("restart_lock_err", 32'(lock_err),   32'd0);
        wait_done(1000, "restart_done_seen");
        check("restart_points",  32'(point_count), 32'd2);
        check("restart_q_empty", 32'(exp_q.size()), 32'd0);

        // Asynchronous reset in the middle of a press
        do_reset();
        clear_counts();
        step = 4'd4;
        stop_freq = 9'd200;
        pulse_start(1'b0);
        tick();
        check("arst_in_press", 32'(next_frequency), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_next_frequency", 32'(next_frequency), 32'd0);
        check("arst_sweep_busy",     32'(sweep_busy),     32'd0);
        check("arst_meas_start",     32'(meas_start),     32'd0);
        repeat (2) tick();
        reset_n = 1'b1;
        repeat (20) tick();
        check("arst_stays_idle",  32'(sweep_busy),     32'd0);
        check("arst_no_press",    32'(next_frequency), 32'd0);
        check("arst_no_done",     32'(done_cnt),       32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
